// File: rtl/recorder_transport_ctrl.sv
// Transport-control FSM for the digital sound recorder.
// Turns play/record/stop key presses into the STOP/REC/PLAY transport state,
// steps the sample-memory address on each sample tick and drives the RAM
// write/read strobes. rec_len remembers how much of the memory holds audio.
// Optional build macro LOOP_PLAY_EN: playback wraps to address 0 at the last
// sample and keeps playing until the stop key is pressed.
module recorder_transport_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_play,
    input  logic              btn_rec,
    input  logic              btn_stop,
    input  logic              sample_tick,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W:0]   rec_len,
    output logic              done
);

    // Encoding is seen directly by the display decoder; 2'b01 is unused.
    typedef enum logic [1:0] {
        StStop = 2'b00,
        StRec  = 2'b10,
        StPlay = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              done_q, done_d;
    logic              play_q, rec_q, stop_q;

    logic              rise_play, rise_rec, rise_stop;
    logic              mem_last;
    logic              play_last;

    assign rise_play = btn_play & ~play_q;
    assign rise_rec  = btn_rec & ~rec_q;
    assign rise_stop = btn_stop & ~stop_q;

    // Top word of memory, and last recorded word during playback.
    assign mem_last  = (addr_q == {ADDR_W{1'b1}});
    assign play_last = (({1'b0, addr_q} + (ADDR_W + 1)'(1)) == rec_len_q);

    // A stop press wins over a tick arriving in the same cycle.
    assign wr_en = (state_q == StRec) & sample_tick & ~rise_stop;
    assign rd_en = (state_q == StPlay) & sample_tick & ~rise_stop;

    assign state   = state_q;
    assign addr    = addr_q;
    assign rec_len = rec_len_q;
    assign done    = done_q;

    // Key history for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_q <= 1'b0;
            rec_q  <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            play_q <= btn_play;
            rec_q  <= btn_rec;
            stop_q <= btn_stop;
        end
    end

    // Transport state, address counter, recorded length and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StStop;
            addr_q    <= '0;
            rec_len_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rec_len_q <= rec_len_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; key priority is stop > rec > play.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rec_len_d = rec_len_q;
        done_d    = 1'b0;
        unique case (state_q)
            StStop: begin
                if (rise_stop) begin
                    state_d = StStop;
                end else if (rise_rec) begin
                    state_d = StRec;
                    addr_d  = '0;
                end else if (rise_play && (rec_len_q != '0)) begin
                    state_d = StPlay;
                    addr_d  = '0;
                end
            end
            StRec: begin
                if (rise_stop) begin
                    rec_len_d = {1'b0, addr_q};
                    addr_d    = '0;
                    state_d   = StStop;
                end else if (sample_tick) begin
                    if (mem_last) begin
                        // Memory full: every word holds audio.
                        rec_len_d = {1'b1, {ADDR_W{1'b0}}};
                        addr_d    = '0;
                        state_d   = StStop;
                        done_d    = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            StPlay: begin
                if (rise_stop) begin
                    addr_d  = '0;
                    state_d = StStop;
                end else if (sample_tick) begin
                    if (play_last) begin
                        addr_d = '0;
                        done_d = 1'b1;
`ifdef LOOP_PLAY_EN
                        state_d = StPlay;
`else
                        state_d = StStop;
`endif
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = StStop;
                addr_d  = '0;
            end
        endcase
    end

endmodule

// File: doc/recorder_transport_ctrl.md
Name: recorder_transport_ctrl

Overview:
Transport-control state machine for the digital sound recorder. Turns the play/record/stop buttons into the 2-bit transport state that drives the four-digit alphabet display ("PLAY", "StOP", " rEC"). Sequences the sample-memory address counter and the write/read strobes, paced by a sample-rate tick. Sits between the debounced key inputs, the sample RAM and the display decoder.

Parameters:
ADDR_W, 10, sample-memory address width; DEPTH = 2**ADDR_W words.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_play  in  1  debounced play key, level, active-high
btn_rec  in  1  debounced record key, level, active-high
btn_stop  in  1  debounced stop key, level, active-high
sample_tick  in  1  one-cycle strobe at the audio sample rate
state  out  2  transport state: STOP=2'b00, REC=2'b10, PLAY=2'b11; 2'b01 is never driven
addr  out  ADDR_W  sample-memory address
wr_en  out  1  write strobe to sample RAM, valid with addr
rd_en  out  1  read strobe to sample RAM, valid with addr
rec_len  out  ADDR_W+1  number of valid recorded words, 0..DEPTH
done  out  1  one-cycle pulse on any automatic return to STOP (memory full / end of playback)

Behaviour:
- Reset (async, rst_n=0): state=STOP, addr=0, rec_len=0, done=0, key history registers=0. wr_en=rd_en=0 while in reset.
- Key edges: each key has a registered previous value. rise_x = btn_x & ~btn_x_q. A key held high produces exactly one rise. Transitions occur on the clock edge where rise_x is first seen (1-cycle latency from key assertion to state change).
- Priority when rises coincide: stop > rec > play.
- STOP:
  - rise_rec -> REC, addr<=0.
  - rise_play with rec_len!=0 -> PLAY, addr<=0.
  - rise_play with rec_len==0 -> ignored, stay STOP.
- REC:
  - wr_en = (state==REC) & sample_tick & ~rise_stop, combinational. Each write advances addr by 1 on that edge.
  - Write with addr==DEPTH-1 (memory full) -> rec_len<=DEPTH, addr<=0, STOP, done=1 next cycle.
  - rise_stop -> rec_len<=addr, addr<=0, STOP. A tick in the same cycle is dropped (no write).
  - rise_play and rise_rec are ignored.
- PLAY:
  - rd_en = (state==PLAY) & sample_tick & ~rise_stop, combinational. Each read advances addr by 1.
  - Read with addr==rec_len-1 (last sample) -> addr<=0, STOP, done=1.
  - rise_stop -> addr<=0, STOP, rec_len unchanged.
  - rise_rec and rise_play are ignored.
- done is registered: high for exactly one cycle after an automatic end, never after a stop key.
- rec_len changes only on leaving REC. Re-recording overwrites from address 0.
- addr never exceeds DEPTH-1. No wrap-around writes.
- The state register is the only source of state. Decoding to display characters is external.

Optional Feature:
LOOP_PLAY_EN
- Defined: on the last sample of playback, addr wraps to 0 and state stays PLAY. done pulses once per wrap. Only a stop key ends playback.
- Undefined: playback ends in STOP as described above.

Test Plan:
- Reset, then idle with random ticks -> state=00, addr=0, wr_en=rd_en=0, rec_len=0; play press is ignored (state stays 00).
- ADDR_W=4: rec press, 5 ticks, stop press -> 5 wr_en pulses at addr 0..4, then state=00, rec_len=5, addr=0, done=0.
- Play after the previous case, ticks continuous -> rd_en at addr 0..4, STOP on the edge after the 5th read, done=1 for one cycle (LOOP_PLAY_EN: addr wraps to 0, state stays 11, done pulses each wrap).
- ADDR_W=4: rec press, 16 ticks -> writes at 0..15, then state=00, rec_len=16, done pulse; a 17th tick causes no write.
- Stop rise coincident with a tick during REC at addr=3 -> no wr_en, rec_len=3. Simultaneous rec+play+stop rises in STOP -> stays STOP. Rec+play rises together -> REC.
- Assert rst_n low mid-PLAY at addr=7 -> state, addr and rd_en clear immediately without waiting for clk. rec_len=0 after reset.
